// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes little-endian 32-bit words
// into instruction memory from address 0, and releases the core once the XOR checksum matches.
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] DEPTH_W16 = 16'(DEPTH_WORDS);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          csum_q, csum_d;
  logic [23:0]         buf_q, buf_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;
  logic [15:0]         len_full;

  assign rx_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept   = rx_valid && rx_ready;
  assign len_full = {rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    buf_d   = buf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      case (state_q)
        S_LEN0: begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d = len_full;
          if (len_full > DEPTH_W16)  state_d = S_ERR;
          else if (len_full == 16'd0) state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Fourth byte bypasses buf so the write issues on this same edge.
            we_d    = 1'b1;
            addr_d  = cnt_q[ADDR_W-1:0];
            wdata_d = {rx_data, buf_q};
            cnt_d   = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == len_q) state_d = S_CSUM;
          end else begin
            buf_d[8*idx_q +: 8] = rx_data;
          end
        end
        S_CSUM: state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = cnt_q;
  assign core_hold    = (state_q != S_DONE);
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory starting at word address 0. It verifies an XOR checksum at the end of the stream. It holds the core (PC and register writes) in reset until the load completes successfully.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: instruction memory capacity in words.
- `ADDR_W`, 6: instruction memory word-address width. Requires `DEPTH_WORDS <= 2**ADDR_W`.

Ports:
- `CLK`, in, 1: single clock. All logic is on the rising edge.
- `RST`, in, 1: reset, asynchronous and active-high.
- `rx_data`, in, 8: incoming stream byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader can accept a byte.
- `imem_we`, out, 1: instruction memory write strobe, one cycle per word.
- `imem_addr`, out, ADDR_W: word address of the write.
- `imem_wdata`, out, 32: instruction word to write.
- `core_hold`, out, 1: 1 holds the core in reset.
- `load_done`, out, 1: load completed and checksum matched.
- `load_err`, out, 1: length overflow or checksum mismatch.
- `words_loaded`, out, 16: number of words written so far.

## Operation
Stream format:
- Length N: 16-bit word count, sent as 2 bytes, little-endian.
- Data: 4·N bytes, each word sent least-significant byte first.
- Checksum: 1 byte, equal to the XOR of all data bytes. Length bytes are excluded.

Handshake and state machine:
- A byte is accepted on a rising edge where `rx_valid && rx_ready`. Any cycle with `rx_valid` low is ignored, and gaps of any length are legal.
- `rx_ready` is decoded combinationally from state. It is 1 in LEN0, LEN1, DATA and CSUM, and 0 in DONE and ERR.
- LEN0: accept the low length byte, then go to LEN1.
- LEN1: accept the high length byte, then:
  - N > `DEPTH_WORDS`: go to ERR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - A 2-bit byte index places each accepted byte into lane `buf[8*i +: 8]`.
  - Each data byte is XORed into an 8-bit running checksum.
  - On acceptance of the 4th byte, at the same edge: register `imem_we<=1`, `imem_addr<=cnt[ADDR_W-1:0]` and `imem_wdata<={byte,buf[23:0]}`, then increment `cnt`.
  - After word N, go to CSUM.
- CSUM: accept one byte.
  - It equals the running XOR: go to DONE.
  - Otherwise: go to ERR.
- DONE: `core_hold=0`, `load_done=1`. Terminal.
- ERR: `core_hold=1`, `load_err=1`. Terminal.
- Leaving DONE or ERR requires `RST`. There is no other re-arm path.

Other rules:
- `words_loaded` equals `cnt`, zero-extended to 16 bits.
- Words already written before an ERR remain in memory. The loader never clears instruction memory.

## Timing
- Reset values:
  - Reset state is LEN0.
  - `rx_ready=1`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`.
  - `core_hold=1`, `load_done=0`, `load_err=0`, `words_loaded=0`.
  - Byte index, checksum and `buf` are all 0.
- Write latency: `imem_we` is high for exactly the one cycle following the edge that accepted a word's 4th byte. Address and data are stable during that cycle.
- The next word's 4th byte cannot arrive sooner than 3 cycles later, so writes never overlap.
- Instruction memory captures the write on the edge that ends the `imem_we` cycle.
- `words_loaded` updates on the same edge that raises `imem_we`.
- `core_hold` falls, and `load_done` rises, on the edge that accepts a matching checksum byte. The core's first fetch of word 0 is the cycle after that edge.
- ERR is entered on the accepting edge of the offending byte (2nd length byte, or checksum byte).
- Reset mid-operation: `RST` asserted in any state immediately forces all reset values and re-asserts `core_hold`. A partially assembled word is discarded and never written.
- Back-to-back bytes are accepted every cycle with no stall.

## Test plan
- **Good load.** Stream `02 00 93 00 50 00 13 01 10 00 C1`, `rx_valid` held high.
  - One-cycle writes: addr 0 ← 0x00500093, then addr 1 ← 0x00100113.
  - Then `load_done=1`, `core_hold=0`, `rx_ready=0`, `words_loaded=2`.
- **Bad checksum.** Same stream with last byte `C0`.
  - Both writes still occur.
  - `load_err=1`, `core_hold=1`, `load_done=0`, `rx_ready=0`.
- **Empty program.** Stream `00 00 00`.
  - No `imem_we` pulse.
  - `load_done=1`, `core_hold=0`, `words_loaded=0`.
- **Length overflow.** With `DEPTH_WORDS=64`, stream `41 00`.
  - ERR on the 2nd byte's edge, `load_err=1`, no writes.
  - Following bytes are not accepted (`rx_ready=0`).
- **Throttled input.** Good-load stream with 0–3 random idle cycles (`rx_valid=0`, garbage `rx_data`) between bytes.
  - Identical writes and final status to the good load.
  - Each `imem_we` pulse is exactly 1 cycle.
- **Reset mid-load.** Assert `RST` after 5 bytes of the good-load stream.
  - All outputs return to reset values asynchronously.
  - Resend the full stream: writes restart at addr 0 and end in `load_done=1`.
